// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, opcode enum and instruction struct
package alu_pkg;

    localparam int ALU_OPW  = 4;
    localparam int ALU_OPCW = 3;

    typedef enum logic [ALU_OPCW-1:0] {
        OPC_ADD  = 3'd0,
        OPC_SUB  = 3'd1,
        OPC_AND  = 3'd2,
        OPC_OR   = 3'd3,
        OPC_XOR  = 3'd4,
        OPC_SHL  = 3'd5,
        OPC_SHR  = 3'd6,
        OPC_PASS = 3'd7
    } alu_opcode_t;

    // Opcode kept as raw bits so every encoding passes through undecoded.
    typedef struct packed {
        logic [ALU_OPCW-1:0] opcode;
        logic [ALU_OPW-1:0]  op1;
        logic [ALU_OPW-1:0]  op2;
    } alu_instr_t;

endpackage

// File: rtl/alu_instr_fifo.sv
// rtl/alu_instr_fifo.sv - synchronous instruction FIFO with push/pop/flush and level
module alu_instr_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = alu_instr_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    // A full FIFO refuses a push even when it also pops this cycle.
    assign push_ok = push & ~flush & (level != LW'(DEPTH));
    assign pop_ok  = pop & ~flush & (level != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - buffered issue stage driving registered ALU operands
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = ALU_OPW,
    parameter int OPCW  = ALU_OPCW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCW-1:0]          in_opcode,
    input  logic [OPW-1:0]           in_op1,
    input  logic [OPW-1:0]           in_op2,
    input  logic                     stall,
    input  logic                     flush,
    output logic [OPCW-1:0]          OPCODE,
    output logic [OPW-1:0]           OP1,
    output logic [OPW-1:0]           OP2,
    output logic                     issue_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               issued_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [OPCW-1:0] opcode;
        logic [OPW-1:0]  op1;
        logic [OPW-1:0]  op2;
    } instr_t;

    instr_t wdata;
    instr_t head;
    logic   push;
    logic   pop;

    // in_ready depends on level alone so the producer sees no combinational loop.
    assign in_ready = (level != LW'(DEPTH));
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = (level != '0) & ~stall & ~flush;
    assign wdata    = '{opcode: in_opcode, op1: in_op1, op2: in_op2};

    alu_instr_fifo #(
        .DEPTH (DEPTH),
        .T     (instr_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (head),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OPCODE      <= '0;
            OP1         <= '0;
            OP2         <= '0;
            issue_valid <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            issue_valid <= pop;
            if (pop) begin
                OPCODE     <= head.opcode;
                OP1        <= head.op1;
                OP2        <= head.op2;
                issued_cnt <= issued_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed self-checking bench for alu_issue_queue
module tb_alu_issue_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [3:0]  in_op1;
    logic [3:0]  in_op2;
    logic        stall;
    logic        flush;
    logic [2:0]  OPCODE;
    logic [3:0]  OP1;
    logic [3:0]  OP2;
    logic        issue_valid;
    logic [2:0]  level;
    logic [7:0]  issued_cnt;
    logic [11:0] obs;

    int checks = 0;
    int passes = 0;

    assign obs = {OPCODE, OP1, OP2, issue_valid};

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(4), .OPW(4), .OPCW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .stall       (stall),
        .flush       (flush),
        .OPCODE      (OPCODE),
        .OP1         (OP1),
        .OP2         (OP2),
        .issue_valid (issue_valid),
        .level       (level),
        .issued_cnt  (issued_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] oc, input logic [3:0] a, input logic [3:0] b);
        in_valid  = v;
        in_opcode = oc;
        in_op1    = a;
        in_op2    = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 4'd0);
        repeat (2) step();
        checks++; if (obs !== 12'h000) $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else passes++;
        checks++; if (issued_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", issued_cnt); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready); else passes++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        drive(1'b1, 3'b111, 4'b0100, 4'b1010);
        step();
        in_valid = 1'b0;
        checks++; if (level !== 3'd1) $display("FAIL single_level1: got %0d expected 1", level); else passes++;
        checks++; if (issue_valid !== 1'b0) $display("FAIL single_early_issue: got %b expected 0", issue_valid); else passes++;
        step();
        checks++; if (obs !== {3'b111, 4'b0100, 4'b1010, 1'b1}) $display("FAIL single_issue: got %h expected %h", obs, {3'b111, 4'b0100, 4'b1010, 1'b1}); else passes++;
        checks++; if (issued_cnt !== 8'd1) $display("FAIL single_cnt: got %0d expected 1", issued_cnt); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL single_level0: got %0d expected 0", level); else passes++;
        step();
        checks++; if (obs !== {3'b111, 4'b0100, 4'b1010, 1'b0}) $display("FAIL single_hold: got %h expected %h", obs, {3'b111, 4'b0100, 4'b1010, 1'b0}); else passes++;
    endtask

    // Entry i carries opcode i+1, op1 i+2, op2 15-i.
    task automatic test_stall_full();
        logic [11:0] exp;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i + 1), 4'(i + 2), 4'(15 - i));
            step();
        end
        checks++; if (level !== 3'd4) $display("FAIL stall_level_full: got %0d expected 4", level); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready_full: got %b expected 0", in_ready); else passes++;
        drive(1'b1, 3'd5, 4'd6, 4'd11);
        step();
        checks++; if (level !== 3'd4) $display("FAIL stall_fifth_held: got %0d expected 4", level); else passes++;
        checks++; if (issue_valid !== 1'b0) $display("FAIL stall_no_issue: got %b expected 0", issue_valid); else passes++;
        stall = 1'b0;
        step();
        checks++; if (obs !== {3'd1, 4'd2, 4'd15, 1'b1}) $display("FAIL full_pop_e0: got %h expected %h", obs, {3'd1, 4'd2, 4'd15, 1'b1}); else passes++;
        checks++; if (level !== 3'd3) $display("FAIL full_pop_level: got %0d expected 3", level); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL full_pop_ready: got %b expected 1", in_ready); else passes++;
        step();
        in_valid = 1'b0;
        checks++; if (obs !== {3'd2, 4'd3, 4'd14, 1'b1}) $display("FAIL stall_e1: got %h expected %h", obs, {3'd2, 4'd3, 4'd14, 1'b1}); else passes++;
        checks++; if (level !== 3'd3) $display("FAIL push_pop_level: got %0d expected 3", level); else passes++;
        for (int i = 2; i < 5; i++) begin
            step();
            exp = {3'(i + 1), 4'(i + 2), 4'(15 - i), 1'b1};
            checks++; if (obs !== exp) $display("FAIL stall_e%0d: got %h expected %h", i, obs, exp); else passes++;
        end
        checks++; if (issued_cnt !== 8'd6) $display("FAIL stall_cnt: got %0d expected 6", issued_cnt); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL stall_drained: got %0d expected 0", level); else passes++;
        step();
        checks++; if (issue_valid !== 1'b0) $display("FAIL stall_empty_valid: got %b expected 0", issue_valid); else passes++;
    endtask

    task automatic test_flush();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'(i + 2), 4'(i + 8), 4'(i + 1));
            step();
        end
        checks++; if (level !== 3'd3) $display("FAIL flush_prefill: got %0d expected 3", level); else passes++;
        flush = 1'b1; stall = 1'b0;
        drive(1'b1, 3'd6, 4'd15, 4'd15);
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (level !== 3'd0) $display("FAIL flush_level: got %0d expected 0", level); else passes++;
        checks++; if (obs !== {3'd5, 4'd6, 4'd11, 1'b0}) $display("FAIL flush_outputs: got %h expected %h", obs, {3'd5, 4'd6, 4'd11, 1'b0}); else passes++;
        checks++; if (issued_cnt !== 8'd6) $display("FAIL flush_cnt: got %0d expected 6", issued_cnt); else passes++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (obs !== {3'd5, 4'd6, 4'd11, 1'b0}) $display("FAIL flush_after%0d: got %h expected %h", i, obs, {3'd5, 4'd6, 4'd11, 1'b0}); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd3, 4'd3, 4'd3);
        step();
        in_valid = 1'b0;
        step();
        stall = 1'b1;
        drive(1'b1, 3'd4, 4'd1, 4'd2);
        step();
        step();
        in_valid = 1'b0;
        checks++; if (level !== 3'd2) $display("FAIL mid_level: got %0d expected 2", level); else passes++;
        checks++; if (issued_cnt !== 8'd7) $display("FAIL mid_cnt: got %0d expected 7", issued_cnt); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if ({obs, level, issued_cnt} !== 23'd0) $display("FAIL mid_async_reset: got %h expected 0", {obs, level, issued_cnt}); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b expected 1", in_ready); else passes++;
        step();
        rst = 1'b0; stall = 1'b0;
        drive(1'b1, 3'd5, 4'd9, 4'd3);
        step();
        in_valid = 1'b0;
        step();
        checks++; if (obs !== {3'd5, 4'd9, 4'd3, 1'b1}) $display("FAIL mid_reissue: got %h expected %h", obs, {3'd5, 4'd9, 4'd3, 1'b1}); else passes++;
        checks++; if (issued_cnt !== 8'd1) $display("FAIL mid_reissue_cnt: got %0d expected 1", issued_cnt); else passes++;
    endtask

    // Instruction k carries opcode k[2:0], op1 k[3:0], op2 ~k[3:0].
    task automatic test_back_to_back();
        logic [7:0]  k;
        logic [11:0] exp;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 1; n <= 257; n++) begin
            if (n <= 256) begin
                k = 8'(n - 1);
                drive(1'b1, k[2:0], k[3:0], ~k[3:0]);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (n == 1) begin
                checks++; if (issue_valid !== 1'b0) $display("FAIL b2b_first_latency: got %b expected 0", issue_valid); else passes++;
            end else begin
                k = 8'(n - 2);
                exp = {k[2:0], k[3:0], ~k[3:0], 1'b1};
                checks++; if (obs !== exp) $display("FAIL b2b_issue%0d: got %h expected %h", n - 2, obs, exp); else passes++;
                checks++; if (issued_cnt !== 8'(n - 1)) $display("FAIL b2b_cnt%0d: got %0d expected %0d", n - 2, issued_cnt, 8'(n - 1)); else passes++;
            end
            if (n <= 256) begin
                checks++; if (level !== 3'd1) $display("FAIL b2b_level%0d: got %0d expected 1", n, level); else passes++;
            end
        end
        checks++; if (issued_cnt !== 8'd0) $display("FAIL b2b_wrap: got %0d expected 0", issued_cnt); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL b2b_final_level: got %0d expected 0", level); else passes++;
        step();
        checks++; if (issue_valid !== 1'b0) $display("FAIL b2b_tail_valid: got %b expected 0", issue_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_full();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Instruction buffer and issue stage sitting directly upstream of the `alu` block. Accepts (opcode, operand1, operand2) triples from the producer over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and issues at most one per cycle onto the ALU's `OPCODE`/`OP1`/`OP2` inputs through registered outputs. Provides downstream stall, synchronous flush, occupancy, and an issued-instruction counter for coverage and debug.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `OPW`, 4: operand width; must match the ALU's `OP1`/`OP2` width.
- `OPCW`, 3: opcode width; must match the ALU's `OPCODE` width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: producer has an instruction.
- `in_ready` out 1: queue can accept; equals `level < DEPTH`.
- `in_opcode` in OPCW: instruction opcode.
- `in_op1` in OPW: first operand.
- `in_op2` in OPW: second operand.
- `stall` in 1: downstream hold; no issue while high.
- `flush` in 1: synchronous queue clear.
- `OPCODE` out OPCW: registered opcode to the ALU.
- `OP1` out OPW: registered operand 1 to the ALU.
- `OP2` out OPW: registered operand 2 to the ALU.
- `issue_valid` out 1: one-cycle pulse per newly issued instruction.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `issued_cnt` out 8: count of issues, wraps 255→0.

## Operation
- Reset (async assert, released synchronously by the caller): `OPCODE`/`OP1`/`OP2` = 0, `issue_valid` = 0, `level` = 0, `issued_cnt` = 0, head/tail pointers = 0; `in_ready` = 1.
- Push: `in_valid & in_ready & !flush` at an edge writes the triple at the tail; tail increments modulo DEPTH.
- Pop/issue: `level != 0 & !stall & !flush` at an edge loads the head entry into `OPCODE`/`OP1`/`OP2`, sets `issue_valid` = 1, increments head modulo DEPTH and `issued_cnt`. Otherwise `issue_valid` = 0 and the output registers hold.
- Simultaneous push and pop: `level` unchanged; both pointers advance.
- Full: `in_ready` = 0 even if a pop happens the same cycle (no same-cycle refill); a push while full is not a handshake and is dropped by definition.
- Empty: no issue; the outputs keep the last issued values; `issue_valid` = 0.
- Stall: holds the outputs and the FIFO; pushes continue until full.
- Flush: priority over push and pop; next cycle `level` = 0, pointers = 0, `issue_valid` = 0; `OPCODE`/`OP1`/`OP2` and `issued_cnt` retained.
- Reset mid-operation: all buffered entries are discarded immediately; there is no partial issue.
- The opcode is not decoded; all 2^OPCW values pass through unchanged.

## Timing
- Accept-to-issue latency is 2 edges when empty and unstalled. Example: `in_valid` is high in cycle 0 and accepted at edge 1; the pop happens at edge 2, and `issue_valid` plus the operands are visible in cycle 2.
- Sustained throughput is 1 instruction/cycle with `in_valid` continuously high and `stall` low; `level` settles at 1.
- `in_ready` is combinational from `level` only (no path from `in_valid`, `stall`, or `flush`).
- `stall` sampled high at edge N: no issue at N; issue resumes at the first edge with `stall` low.

## Structure
- Shared package `alu_pkg`: `OPW`/`OPCW` defaults, the opcode enum, and the `alu_instr_t` struct {opcode, op1, op2}. The ALU, this block, and benches all import it.
- One sub-module, `alu_instr_fifo`: a parameterized synchronous FIFO of `alu_instr_t` with push/pop/flush and level. `alu_issue_queue` adds the issue registers, stall logic, and counter.

## Test plan
- Reset, then push {111, 0100, 1010} with `stall` = 0: `issue_valid` pulses in cycle 2 with `OPCODE` = 111, `OP1` = 0100, `OP2` = 1010; `issued_cnt` = 1.
- Hold `stall` = 1, push 5 instructions: the first 4 are accepted, `in_ready` = 0 at `level` = 4, the 5th is held by the producer. Release `stall`: 4 issues on consecutive cycles in FIFO order, then the 5th.
- Full queue with `in_valid` high and `stall` low: `in_ready` stays 0 for the pop cycle and returns to 1 with `level` = 3.
- `flush` with `level` = 3 and a concurrent push: next cycle `level` = 0, `issue_valid` = 0, outputs unchanged, the pushed triple is never issued.
- Assert `rst` mid-stream (`level` = 2, `issued_cnt` = 7): all outputs go to 0 immediately; after release, a new push issues normally with `issued_cnt` = 1.
- Issue 256 instructions back-to-back: `issued_cnt` wraps to 0; no bubbles after the initial 2-cycle latency.
